// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus_uart slice: register offsets, STATUS bit
// positions and the common TX/RX frame state type.
package bus_uart_pkg;

   localparam logic [1:0] OFS_DATA = 2'd0;
   localparam logic [1:0] OFS_STAT = 2'd1;
   localparam logic [1:0] OFS_DIVL = 2'd2;
   localparam logic [1:0] OFS_DIVH = 2'd3;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_AVAIL  = 2;
   localparam int ST_RX_FULL   = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_FRAME_ERR = 5;
   localparam int ST_TX_BUSY   = 6;
   localparam int ST_LOOPBACK  = 7;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

   // Divider values 0 and 1 both mean one clock per bit.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd2) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/bus_uart_if.sv
// CPU byte-bus bundle: valid/ready request, address/data, and the hit decode
// that lets the top mux this target against main memory.
interface bus_uart_if;

   logic        valid;
   logic        write;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        ready;
   logic        hit;

   modport master (
      output valid, write, addr, wdata,
      input  rdata, ready, hit
   );

   modport slave (
      input  valid, write, addr, wdata,
      output rdata, ready, hit
   );

endinterface

// File: rtl/bus_uart_fifo.sv
// DEPTH x 8 show-ahead FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module bus_uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic [7:0]  mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART on the CPU byte bus: DATA/STATUS/DIV registers,
// buffered TX and RX. Define BUS_UART_LOOPBACK_EN for the STATUS[7] loopback.
module bus_uart
   import bus_uart_pkg::*;
#(
   parameter logic [15:0] BASE    = 16'h1010,
   parameter int          DEPTH   = 4,
   parameter logic [15:0] DIV_RST = 16'd434
) (
   input  logic      clk,
   input  logic      rstb,
   bus_uart_if.slave bus,
   output logic      txd,
   input  logic      rxd
);

   logic        ready_q, ready_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [15:0] div_q, div_d;
   logic        overrun_q, overrun_d;
   logic        ferr_q, ferr_d;

   uart_st_t    tx_st_q, tx_st_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        txd_q, txd_d;

   logic        sync1_q, sync2_q, sync3_q;
   uart_st_t    rx_st_q, rx_st_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic [2:0]  rx_bit_q, rx_bit_d;

   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]  tx_dout;
   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]  rx_dout;
   logic        rx_ovr_set, rx_ferr_set;

   logic        cap_rd, cap_wr;
   logic [1:0]  ofs;
   logic [15:0] div_e, half_e;
   logic [7:0]  status;
   logic        loop_en;
   logic        rx_src;

   assign bus.hit   = bus.valid && (bus.addr[15:2] == BASE[15:2]);
   assign bus.ready = ready_q;
   assign bus.rdata = rdata_q;

   assign ofs    = bus.addr[1:0];
   assign cap_rd = bus.hit && !ready_q && !bus.write;
   assign cap_wr = bus.hit && !ready_q && bus.write;

   assign div_e  = eff_div(div_q);
   assign half_e = ((div_e >> 1) == 16'd0) ? 16'd1 : (div_e >> 1);

`ifdef BUS_UART_LOOPBACK_EN
   logic loop_q, loop_d;

   always_comb begin
      loop_d = loop_q;
      if (cap_wr && ofs == OFS_STAT) loop_d = bus.wdata[ST_LOOPBACK];
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) loop_q <= 1'b0;
      else       loop_q <= loop_d;
   end

   assign loop_en = loop_q;
`else
   assign loop_en = 1'b0;
`endif

   // In loopback the RX path listens to the shifter and the pin stays idle.
   assign rx_src = loop_en ? txd_q : rxd;
   assign txd    = loop_en ? 1'b1 : txd_q;

   always_comb begin
      status               = '0;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_RX_AVAIL]  = !rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_OVERRUN]   = overrun_q;
      status[ST_FRAME_ERR] = ferr_q;
      status[ST_TX_BUSY]   = (tx_st_q != IDLE);
      status[ST_LOOPBACK]  = loop_en;
   end

   bus_uart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (bus.wdata),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty)
   );

   bus_uart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_sh_q),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // Register file: every access is performed once, on the capture cycle.
   always_comb begin
      ready_d   = bus.hit;
      rdata_d   = rdata_q;
      div_d     = div_q;
      tx_push   = 1'b0;
      rx_pop    = 1'b0;
      overrun_d = overrun_q;
      ferr_d    = ferr_q;
      if (cap_rd) begin
         case (ofs)
            OFS_DATA: begin
               rdata_d = rx_empty ? 8'h00 : rx_dout;
               rx_pop  = !rx_empty;
            end
            OFS_STAT: rdata_d = status;
            OFS_DIVL: rdata_d = div_q[7:0];
            default:  rdata_d = div_q[15:8];
         endcase
      end
      if (cap_wr) begin
         case (ofs)
            OFS_DATA: tx_push = 1'b1;
            OFS_STAT: begin
               if (bus.wdata[ST_OVERRUN])   overrun_d = 1'b0;
               if (bus.wdata[ST_FRAME_ERR]) ferr_d    = 1'b0;
            end
            OFS_DIVL: div_d[7:0]  = bus.wdata;
            default:  div_d[15:8] = bus.wdata;
         endcase
      end
      if (rx_ovr_set)  overrun_d = 1'b1;
      if (rx_ferr_set) ferr_d    = 1'b1;
   end

   // TX: the counter is reloaded from DIV at each bit boundary.
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_sh_d  = tx_sh_q;
      tx_bit_d = tx_bit_q;
      txd_d    = txd_q;
      tx_pop   = 1'b0;
      case (tx_st_q)
         IDLE: begin
            txd_d = 1'b1;
            if (!tx_empty) begin
               tx_pop   = 1'b1;
               tx_sh_d  = tx_dout;
               tx_cnt_d = div_e - 16'd1;
               tx_st_d  = START;
               txd_d    = 1'b0;
            end
         end
         START: begin
            if (tx_cnt_q == 16'd0) begin
               tx_st_d  = DATA;
               tx_cnt_d = div_e - 16'd1;
               tx_bit_d = 3'd0;
               txd_d    = tx_sh_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d = div_e - 16'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_st_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  txd_d    = tx_sh_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         default: begin
            if (tx_cnt_q == 16'd0) begin
               if (!tx_empty) begin
                  tx_pop   = 1'b1;
                  tx_sh_d  = tx_dout;
                  tx_cnt_d = div_e - 16'd1;
                  tx_st_d  = START;
                  txd_d    = 1'b0;
               end else begin
                  tx_st_d = IDLE;
                  txd_d   = 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
      endcase
   end

   // RX: half-bit wait after the start edge puts every sample mid-bit.
   always_comb begin
      rx_st_d     = rx_st_q;
      rx_cnt_d    = rx_cnt_q;
      rx_sh_d     = rx_sh_q;
      rx_bit_d    = rx_bit_q;
      rx_push     = 1'b0;
      rx_ovr_set  = 1'b0;
      rx_ferr_set = 1'b0;
      case (rx_st_q)
         IDLE: begin
            if (sync3_q && !sync2_q) begin
               rx_st_d  = START;
               rx_cnt_d = half_e - 16'd1;
            end
         end
         START: begin
            if (rx_cnt_q == 16'd0) begin
               if (sync2_q) begin
                  rx_st_d = IDLE;
               end else begin
                  rx_st_d  = DATA;
                  rx_cnt_d = div_e - 16'd1;
                  rx_bit_d = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (rx_cnt_q == 16'd0) begin
               rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
               rx_cnt_d = div_e - 16'd1;
               if (rx_bit_q == 3'd7) rx_st_d = STOP;
               else                  rx_bit_d = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         default: begin
            if (rx_cnt_q == 16'd0) begin
               rx_st_d = IDLE;
               if (sync2_q) begin
                  rx_push    = 1'b1;
                  rx_ovr_set = rx_full && !rx_pop;
               end else begin
                  rx_ferr_set = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ready_q   <= 1'b0;
         rdata_q   <= 8'h00;
         div_q     <= DIV_RST;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
         tx_st_q   <= IDLE;
         tx_cnt_q  <= '0;
         tx_sh_q   <= '0;
         tx_bit_q  <= '0;
         txd_q     <= 1'b1;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         sync3_q   <= 1'b1;
         rx_st_q   <= IDLE;
         rx_cnt_q  <= '0;
         rx_sh_q   <= '0;
         rx_bit_q  <= '0;
      end else begin
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         div_q     <= div_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
         tx_st_q   <= tx_st_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_sh_q   <= tx_sh_d;
         tx_bit_q  <= tx_bit_d;
         txd_q     <= txd_d;
         sync1_q   <= rx_src;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_sh_q   <= rx_sh_d;
         rx_bit_q  <= rx_bit_d;
      end
   end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: directed register/serial cases plus a
// randomized mix checked against a queue-based model of the UART.
module tb_bus_uart;

   localparam int          DEPTH  = 4;
   localparam logic [15:0] A_DATA = 16'h1010;
   localparam logic [15:0] A_STAT = 16'h1011;
   localparam logic [15:0] A_DIVL = 16'h1012;
   localparam logic [15:0] A_DIVH = 16'h1013;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic rxd = 1'b1;
   logic txd;

   bus_uart_if bus ();

   bus_uart dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus),
      .txd  (txd),
      .rxd  (rxd)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model of the RX side and TX line decoder.
   logic [7:0] rx_m[$];
   logic       ovr_m  = 1'b0;
   logic       ferr_m = 1'b0;
   int         mon_div = 434;
   logic [7:0] tx_q[$];
   int         tx_t[$];
   int         tx_bad = 0;

   function automatic logic [7:0] status_model();
      logic [7:0] s;
      s    = 8'h02;
      s[2] = (rx_m.size() != 0);
      s[3] = (rx_m.size() == DEPTH);
      s[4] = ovr_m;
      s[5] = ferr_m;
      return s;
   endfunction

   initial begin : tx_monitor
      int d, t0;
      logic [7:0] b;
      logic okf, prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rstb) begin
            prev = 1'b1;
         end else if (prev && !txd) begin
            d   = mon_div;
            t0  = cyc;
            okf = 1'b1;
            repeat (d / 2) @(negedge clk);
            if (txd !== 1'b0) okf = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (d) @(negedge clk);
               b[i] = txd;
            end
            repeat (d) @(negedge clk);
            if (txd !== 1'b1) okf = 1'b0;
            if (!okf) tx_bad++;
            tx_q.push_back(b);
            tx_t.push_back(t0);
            prev = txd;
         end else begin
            prev = txd;
         end
      end
   end

   task automatic bus_xfer(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] r);
      int t;
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.write = wr; bus.addr = a; bus.wdata = d;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!bus.ready && t < 16);
      check("bus_ready", bus.ready, 1'b1);
      r = bus.rdata;
      bus.valid = 1'b0;
      @(posedge clk); #1;
      if (wr) $display("bus wr addr=%h data=%h", a, d);
      else    $display("bus rd addr=%h data=%h", a, r);
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      logic [7:0] r;
      bus_xfer(1'b1, a, d, r);
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [7:0] r);
      bus_xfer(1'b0, a, 8'h00, r);
   endtask

   task automatic set_div(input int d);
      bus_wr(A_DIVL, d[7:0]);
      bus_wr(A_DIVH, d[15:8]);
      mon_div = (d < 2) ? 1 : d;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stopb, input int d);
      logic [9:0] bits;
      bits = {stopb, b, 1'b0};
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         repeat (d) @(posedge clk);
         #1;
      end
      rxd = 1'b1;
      repeat (d + 4) @(posedge clk);
      #1;
      if (stopb) begin
         if (rx_m.size() < DEPTH) rx_m.push_back(b);
         else                     ovr_m = 1'b1;
      end else begin
         ferr_m = 1'b1;
      end
      $display("rx frame data=%h stop=%0d div=%0d", b, stopb, d);
   endtask

   task automatic wait_tx(input int n, input int budget);
      int t;
      t = 0;
      while (tx_q.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("tx_frames_seen", tx_q.size(), n);
   endtask

   function automatic int pop_tx();
      if (tx_q.size() == 0) return -1;
      return int'(tx_q.pop_front());
   endfunction

   task automatic drain_rx(input string tag);
      logic [7:0] r;
      while (rx_m.size() != 0) begin
         bus_rd(A_DATA, r);
         check(tag, r, rx_m.pop_front());
      end
   endtask

   initial begin : watchdog
      #(900_000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [7:0] r;
      logic [7:0] exp_q[$];
      int d, k, j, t0;
      bus.valid = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;

      // Reset values
      repeat (3) @(posedge clk); #1;
      check("rst_txd", txd, 1'b1);
      check("rst_ready", bus.ready, 1'b0);
      check("rst_rdata", bus.rdata, 8'h00);
      rstb = 1'b1;
      repeat (2) @(posedge clk); #1;
      check("idle_ready", bus.ready, 1'b0);
      bus_rd(A_STAT, r); check("rst_status", r, 8'h02);
      bus_rd(A_DIVL, r); check("rst_divl", r, 8'hB2);
      bus_rd(A_DIVH, r); check("rst_divh", r, 8'h01);

      // Address decode and non-hit behaviour
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.write = 1'b0; bus.addr = 16'h1014;
      repeat (3) @(posedge clk); #1;
      check("nohit_hit", bus.hit, 1'b0);
      check("nohit_ready", bus.ready, 1'b0);
      check("nohit_rdata_held", bus.rdata, 8'h01);
      bus.addr = 16'h100F; #1;
      check("below_base_hit", bus.hit, 1'b0);
      bus.addr = A_DIVH; #1;
      check("top_of_range_hit", bus.hit, 1'b1);
      bus.valid = 1'b0; #1;
      check("novalid_hit", bus.hit, 1'b0);
      @(posedge clk); #1;

      // Single TX frame, DIV=4
      set_div(4);
      bus_wr(A_DATA, 8'h55);
      bus_rd(A_STAT, r); check("tx_busy_mid", r[6], 1'b1);
      wait_tx(1, 200);
      check("tx_55", pop_tx(), 32'h55);
      check("tx_55_framing", tx_bad, 0);
      repeat (10) @(posedge clk);
      bus_rd(A_STAT, r); check("tx_done_status", r, 8'h02);

      // DIV=0 behaves as one clock per bit
      set_div(0);
      bus_wr(A_DATA, 8'hC3);
      wait_tx(1, 100);
      check("tx_div0", pop_tx(), 32'hC3);
      check("tx_div0_framing", tx_bad, 0);
      repeat (5) @(posedge clk);

      // TX FIFO overflow, DIV=100
      set_div(100);
      tx_t.delete();
      for (int i = 1; i <= 6; i++) bus_wr(A_DATA, 8'(i));
      bus_rd(A_STAT, r); check("tx_full_status", r, 8'h41);
      wait_tx(5, 6000);
      for (int i = 1; i <= 5; i++) check("tx_fifo_order", pop_tx(), i);
      for (int i = 1; i < 5 && i < tx_t.size(); i++)
         check("tx_back_to_back_gap", tx_t[i] - tx_t[i-1], 1000);
      check("tx_full_framing", tx_bad, 0);
      repeat (200) @(posedge clk);
      bus_rd(A_STAT, r); check("tx_drop_status", r, 8'h02);
      check("tx_no_sixth", tx_q.size(), 0);

      // RX single frame, DIV=8
      set_div(8);
      send_frame(8'hA3, 1'b1, 8);
      bus_rd(A_STAT, r); check("rx_avail_status", r, status_model());
      drain_rx("rx_a3");
      bus_rd(A_DATA, r); check("rx_empty_read", r, 8'h00);
      bus_rd(A_STAT, r); check("rx_empty_status", r, 8'h02);

      // Framing error and write-1-to-clear
      send_frame(8'h3C, 1'b0, 8);
      bus_rd(A_STAT, r); check("ferr_status", r, status_model());
      bus_wr(A_STAT, 8'h20); ferr_m = 1'b0;
      bus_rd(A_STAT, r); check("ferr_clear", r, status_model());

      // Overrun: DEPTH+1 good frames unread
      for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1'b1, 8);
      bus_rd(A_STAT, r); check("overrun_status", r, status_model());
      drain_rx("overrun_data");
      bus_rd(A_DATA, r); check("overrun_empty", r, 8'h00);
      bus_wr(A_STAT, 8'h10); ovr_m = 1'b0;
      bus_rd(A_STAT, r); check("overrun_clear", r, status_model());

      // Randomized TX/RX mix
      for (int it = 0; it < 8; it++) begin
         d = $urandom_range(6, 12);
         set_div(d);
         k = $urandom_range(1, 4);
         exp_q.delete();
         for (int i = 0; i < k; i++) begin
            exp_q.push_back(8'($urandom));
            bus_wr(A_DATA, exp_q[i]);
         end
         j = $urandom_range(1, 5);
         for (int i = 0; i < j; i++)
            send_frame(8'($urandom), ($urandom_range(0, 5) != 0), d);
         wait_tx(k, k * 10 * d + 200);
         for (int i = 0; i < k; i++) check("rand_tx", pop_tx(), exp_q[i]);
         check("rand_tx_framing", tx_bad, 0);
         repeat (d) @(posedge clk);
         bus_rd(A_STAT, r); check("rand_status", r, status_model());
         drain_rx("rand_rx");
         bus_wr(A_STAT, 8'h30); ovr_m = 1'b0; ferr_m = 1'b0;
         bus_rd(A_STAT, r); check("rand_clear", r, status_model());
      end

      // Reset during a TX data bit
      set_div(8);
      bus_wr(A_DATA, 8'h96);
      repeat (34) @(posedge clk);
      #1;
      rstb = 1'b0; #1;
      check("rst_mid_tx_txd", txd, 1'b1);
      check("rst_mid_tx_ready", bus.ready, 1'b0);
      repeat (2) @(posedge clk); #1;
      rstb = 1'b1;
      mon_div = 434;
      bus_rd(A_STAT, r); check("rst_mid_tx_status", r, 8'h02);

      // Reset during an RX data bit
      set_div(8);
      @(posedge clk); #1;
      rxd = 1'b0;
      t0 = cyc;
      repeat (8 * 4) @(posedge clk);
      #1;
      rstb = 1'b0;
      rxd  = 1'b1;
      repeat (2) @(posedge clk); #1;
      rstb = 1'b1;
      mon_div = 434;
      repeat (150) @(posedge clk);
      check("rst_mid_rx_elapsed", (cyc - t0) > 150, 1'b1);
      bus_rd(A_STAT, r); check("rst_mid_rx_status", r, 8'h02);
      bus_rd(A_DATA, r); check("rst_mid_rx_nobyte", r, 8'h00);
      tx_q.delete(); tx_t.delete(); tx_bad = 0;

`ifdef BUS_UART_LOOPBACK_EN
      set_div(8);
      bus_wr(A_STAT, 8'h80);
      bus_rd(A_STAT, r); check("lb_status_set", r, 8'h82);
      bus_wr(A_DATA, 8'h5A);
      k = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) k++;
      end
      check("lb_txd_pin_idle", k, 0);
      bus_rd(A_STAT, r); check("lb_rx_status", r, 8'h86);
      bus_rd(A_DATA, r); check("lb_rx_data", r, 8'h5A);
      bus_wr(A_STAT, 8'h00);
      bus_rd(A_STAT, r); check("lb_status_off", r, 8'h02);
      check("lb_no_pin_frames", tx_q.size(), 0);
`else
      bus_wr(A_STAT, 8'h80);
      bus_rd(A_STAT, r); check("no_lb_bit7", r, 8'h02);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_uart.md
Name: bus_uart

Overview:
- Memory-mapped 8N1 UART target on the CPU's 8-bit valid/ready byte bus.
- Sits downstream of the CPU alongside main memory. The top muxes rdata/ready by `hit`.
- Provides the CPU with buffered TX/RX serial I/O and a programmable baud divider.

Parameters:
BASE, 16'h1010, byte address of register 0; decode uses addr[15:2]==BASE[15:2], so BASE[1:0] must be 0
DEPTH, 4, entries per TX and RX FIFO; power of two, at least 2
DIV_RST, 16'd434, reset value of the baud divider (clk cycles per bit)

Ports:
clk    input   1   clock, all state on posedge
rstb   input   1   asynchronous active-low reset
valid  input   1   bus request from CPU
write  input   1   1 = write, 0 = read; qualified by valid
addr   input   16  byte address
wdata  input   8   write data
rdata  output  8   read data, held while ready=1
ready  output  1   registered acknowledge; high only for hits
hit    output  1   combinational: valid && addr in [BASE, BASE+3]
txd    output  1   serial out, idle high
rxd    input   1   serial in, asynchronous to clk

Behaviour:
- Reset (async, rstb=0):
  - ready=0, rdata=0, txd=1.
  - FIFOs empty, sticky flags 0, DIV=DIV_RST.
  - TX and RX FSMs return to IDLE.
  - A frame in progress is abandoned, with no partial byte pushed.
- Handshake, per posedge:
  - Capture cycle: hit && !ready. The access is performed exactly once here.
  - ready <= hit.
  - CPU drops valid after seeing ready; ready falls the cycle after.
  - A second access needs valid low for at least one cycle in between.
- Registers, offset from BASE:
  - +0 DATA.
    - Write pushes TX FIFO; if TX FIFO is full the byte is dropped silently.
    - Read pops RX FIFO; if RX FIFO is empty it returns 0 and nothing pops.
  - +1 STATUS read: [0] tx_full, [1] tx_empty, [2] rx_avail, [3] rx_full, [4] overrun, [5] frame_err, [6] tx_busy, [7] loopback (0 if feature off).
  - +1 STATUS write:
    - Bits 4 and 5 are write-1-to-clear.
    - Bit 7 sets loopback (feature on only).
    - Other bits are ignored.
  - +2 DIV_LO and +3 DIV_HI: read/write. A DIV value of 0 or 1 behaves as 1.
- rdata is registered at the capture cycle and holds until the next capture.
- Non-hit reads never change rdata; the top ignores rdata when hit is low.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE→START when the FIFO is not empty. The head is popped into the shifter on that transition.
  - Each state lasts DIV cycles, driven by a 16-bit down-counter.
  - DATA shifts 8 bits LSB first, then moves to STOP.
  - STOP→START if the FIFO is not empty (back-to-back frames, no idle gap), otherwise →IDLE.
  - tx_busy = state != IDLE.
  - A DIV write mid-frame takes effect at the next bit boundary.
- RX path: rxd passes through a 2-flop synchronizer.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE→START on a falling edge of the synchronized rxd.
  - START waits DIV/2 (floor, minimum 1), then samples. If high it is a glitch and returns to IDLE.
  - DATA samples every DIV cycles, 8 bits LSB first.
  - STOP samples once after DIV cycles.
  - Stop=1 pushes the byte; if the RX FIFO is full the byte is dropped and overrun is set.
  - Stop=0 sets frame_err and drops the byte.
  - After the STOP sample the FSM returns to IDLE.
- Simultaneous events:
  - CPU pop and RX push in the same cycle on a full FIFO: pop first, push succeeds, no overrun.
  - CPU push and TX pop in the same cycle on a full FIFO: both succeed.
  - Flag clear and flag set in the same cycle: set wins.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.

Optional Feature:
- BUS_UART_LOOPBACK_EN defined:
  - STATUS[7] is a R/W loopback bit.
  - When 1, the RX synchronizer input is the internal txd instead of rxd, and the txd pin is held at 1.
- Undefined:
  - STATUS[7] reads 0 and writes to it are ignored.
  - RX is always fed from the rxd pin.

Decomposition:
- Package bus_uart_pkg holds:
  - register offsets OFS_DATA=0, OFS_STAT=1, OFS_DIVL=2, OFS_DIVH=3;
  - STATUS bit indices;
  - enum uart_st_t {IDLE, START, DATA, STOP}, shared by TX and RX.
- Sub-module bus_uart_fifo: parameterized DEPTH×8 synchronous FIFO with push, pop, dout (head, show-ahead), full, empty. Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset: after rstb deassert, read STATUS → 8'h02 (tx_empty); read DIV_LO/HI → 8'hB2/8'h01; txd=1; ready=0 before any access.
- TX frame, DIV=4: write DATA=8'h55.
  - txd goes low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - tx_busy=1 throughout; STATUS reads 8'h02 once done.
- TX FIFO full, DEPTH=4, DIV=100: write 6 bytes 8'h01..8'h06 quickly. One byte is in the shifter and 8'h06 is dropped; serial output is 01,02,03,04,05 with no gaps.
- RX with DIV=8: drive frame 8'hA3 on rxd → STATUS[2]=1; read DATA → 8'hA3; second read → 8'h00 and rx_avail=0.
- RX errors:
  - Drive frame 8'h3C with stop bit 0 → STATUS[5]=1, FIFO empty.
  - Write STATUS=8'h20 → bit 5 clears.
  - Send DEPTH+1 valid frames without reading → overrun=1 and FIFO holds the first 4 bytes.
- Reset mid-frame: assert rstb during TX DATA bit 3 and again during RX DATA → txd=1 immediately, FIFOs empty, no stray RX byte after release. With BUS_UART_LOOPBACK_EN, write STATUS=8'h80 then DATA=8'h5A → RX FIFO receives 8'h5A and the txd pin stays 1.
